led_fade_array: RTL and testbench
=================================

LED_FADE_ARRAY -- requirements
Module: led_fade_array

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of independent LED channels (1..16).
REQ-002 SHALL have parameter PWM_INTERVAL, default 1200: clocks per PWM period (100 us at 12 MHz).
REQ-003 SHALL have parameter UPDATE_PERIODS, default 100: PWM periods between fade/blink updates.
REQ-004 SHALL have parameter STEP, default 12: duty increment/decrement per update in BREATHE mode.
REQ-005 SHALL have parameter ACTIVE_LOW, default 1: 1 drives LED-on as logic 0.
REQ-006 SHALL define DW = $clog2(PWM_INTERVAL+1), so a duty of PWM_INTERVAL (100 %) is representable.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port wr_en, input, 1 bit: configuration write strobe.
REQ-010 SHALL have port wr_ch, input, $clog2(N_CH) bits (minimum 1): target channel.
REQ-011 SHALL have port wr_mode, input, 2 bits: 0 OFF, 1 STATIC, 2 BREATHE, 3 BLINK.
REQ-012 SHALL have port wr_level, input, DW bits: channel target duty.
REQ-013 SHALL have port pwm_out, output, N_CH bits: per-channel LED drive.
REQ-014 SHALL have port period_tick, output, 1 bit: one-cycle pulse on the last clock of each PWM period.
REQ-015 SHALL have port update_tick, output, 1 bit: one-cycle pulse on the period_tick that triggers an update.

Function
REQ-016 SHALL run a shared counter pwm_cnt that counts 0..PWM_INTERVAL-1 and wraps to 0.
REQ-017 SHALL assert period_tick combinationally while pwm_cnt == PWM_INTERVAL-1.
REQ-018 SHALL run a shared counter upd_cnt that advances on each period_tick over 0..UPDATE_PERIODS-1 and wraps to 0.
REQ-019 SHALL assert update_tick when period_tick is high and upd_cnt == UPDATE_PERIODS-1.
REQ-020 SHALL keep per-channel state: mode, target, working duty, direction bit, and applied duty.
REQ-021 SHALL copy working duty into applied duty only on period_tick edges, so duty never changes mid-period.
REQ-022 SHALL register pwm_out[i] = (pwm_cnt < applied[i]), XOR ACTIVE_LOW; this gives exactly one cycle of latency.
REQ-023 SHALL, for applied = 0, produce a constant inactive output, and for applied = PWM_INTERVAL, a constant active output.
REQ-024 SHALL, in OFF mode, hold working duty at 0.
REQ-025 SHALL, in STATIC mode, set working duty equal to target on every clock.
REQ-026 SHALL, in BREATHE mode on update_tick while counting up, set duty = min(duty+STEP, target); on reaching target, set direction down.
REQ-027 SHALL, in BREATHE mode on update_tick while counting down, set duty = 0 if duty ≤ STEP, else duty-STEP; on reaching 0, set direction up.
REQ-028 SHALL, in BREATHE mode with target = 0, hold duty at 0 with no direction toggling.
REQ-029 SHALL, in BLINK mode on update_tick, toggle working duty between 0 and target, starting from 0.
REQ-030 SHALL, on wr_en with wr_ch < N_CH, load mode and target at the next edge, clamp target to PWM_INTERVAL, clear duty to 0, and set direction up.
REQ-031 SHALL ignore wr_en when wr_ch ≥ N_CH; no state changes.
REQ-032 SHALL, when a write and update_tick coincide on the same channel, apply the write and drop the update.
REQ-033 SHALL make new configuration visible on pwm_out only from the PWM period after the next period_tick.
REQ-034 SHALL compute all arithmetic at DW+1 bits so that duty+STEP cannot overflow before clamping.

Reset
REQ-035 SHALL, on rst_n low, asynchronously clear pwm_cnt, upd_cnt, every mode (to OFF), target, duty, direction and applied duty.
REQ-036 SHALL, during reset, drive pwm_out to the inactive level: all ones if ACTIVE_LOW, else zeros.
REQ-037 SHALL hold period_tick and update_tick at 0 during reset.
REQ-038 SHALL take effect immediately on a mid-period reset, and counting SHALL restart from 0 at the first clock after release.

Verification
REQ-039 SHALL cover: PWM_INTERVAL=10, STATIC level 3 on ch0 -> pwm_out[0] active exactly 3 of every 10 clocks, starting the period after the next period_tick.
REQ-040 SHALL cover: BREATHE target 4, STEP 2, UPDATE_PERIODS 2 -> applied duty sequence 0,2,4,2,0,2, changing every 2 periods.
REQ-041 SHALL cover: STATIC level 15 with PWM_INTERVAL=10 -> clamped to 10, constant active output; STATIC level 0 -> constant inactive output.
REQ-042 SHALL cover: BLINK target 10 -> output alternates between full-on and full-off every UPDATE_PERIODS periods.
REQ-043 SHALL cover: N_CH=3 with wr_ch=3 -> no channel changes; a write coinciding with update_tick -> write wins.
REQ-044 SHALL cover: rst_n pulsed low mid-period during BREATHE -> outputs go inactive immediately, pwm_cnt restarts at 0, and the mode reads back as OFF.

Source files
------------

// File: rtl/led_fade_array.sv
// led_fade_array: multi-channel LED PWM driver with OFF, STATIC, BREATHE and
// BLINK modes. All channels share one PWM period counter and one update
// counter; each channel keeps its own mode, target, working and applied duty.
module led_fade_array #(
   parameter int  N_CH           = 3,
   parameter int  PWM_INTERVAL   = 1200,
   parameter int  UPDATE_PERIODS = 100,
   parameter int  STEP           = 12,
   parameter int  ACTIVE_LOW     = 1,
   localparam int DW             = $clog2(PWM_INTERVAL + 1),
   localparam int CHW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [CHW-1:0]  wr_ch,
   input  logic [1:0]      wr_mode,
   input  logic [DW-1:0]   wr_level,
   output logic [N_CH-1:0] pwm_out,
   output logic            period_tick,
   output logic            update_tick
);

   localparam int UW = (UPDATE_PERIODS > 1) ? $clog2(UPDATE_PERIODS) : 1;

   localparam logic [DW-1:0] L_CNT_LAST = DW'(PWM_INTERVAL - 1);
   localparam logic [DW-1:0] L_FULL     = DW'(PWM_INTERVAL);
   localparam logic [UW-1:0] L_UPD_LAST = UW'(UPDATE_PERIODS - 1);
   // Step at one extra bit so duty + STEP never wraps before clamping
   localparam logic [DW:0]   L_STEP_X   = (DW + 1)'(STEP);
   localparam logic [DW-1:0] L_STEP     = DW'(STEP);
   // Output level of a dark LED
   localparam logic          L_IDLE     = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_STATIC  = 2'd1;
   localparam logic [1:0] MODE_BREATHE = 2'd2;

   logic [DW-1:0] r_pwm_cnt;
   logic [UW-1:0] r_upd_cnt;
   logic          w_period_tick;
   logic          w_update_tick;
   logic [DW-1:0] w_level;

   // Ticks are gated with rst_n so they stay low for the whole reset
   assign w_period_tick = rst_n && (r_pwm_cnt == L_CNT_LAST);
   assign w_update_tick = w_period_tick && (r_upd_cnt == L_UPD_LAST);
   assign period_tick   = w_period_tick;
   assign update_tick   = w_update_tick;

   // Requested level clamped to 100 % duty
   assign w_level = (wr_level > L_FULL) ? L_FULL : wr_level;

   // Shared PWM period counter, 0..PWM_INTERVAL-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt <= '0;
      end else if (w_period_tick) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + DW'(1);
      end
   end

   // Shared update counter, advances once per PWM period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_upd_cnt <= '0;
      end else if (w_update_tick) begin
         r_upd_cnt <= '0;
      end else if (w_period_tick) begin
         r_upd_cnt <= r_upd_cnt + UW'(1);
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam logic [CHW-1:0] L_ID = CHW'(gi);

      logic [1:0]    r_mode;
      logic [DW-1:0] r_target;
      logic [DW-1:0] r_duty;
      logic          r_dir_down;
      logic [DW-1:0] r_applied;
      logic          r_pwm;
      logic          w_wr_hit;
      logic [DW:0]   w_sum;

      // Out-of-range channel numbers never match any instance
      assign w_wr_hit = wr_en && (wr_ch == L_ID);
      assign w_sum    = {1'b0, r_duty} + L_STEP_X;

      // Configuration load and working-duty evolution; a write beats an update
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_mode     <= MODE_OFF;
            r_target   <= '0;
            r_duty     <= '0;
            r_dir_down <= 1'b0;
         end else if (w_wr_hit) begin
            r_mode     <= wr_mode;
            r_target   <= w_level;
            r_duty     <= '0;
            r_dir_down <= 1'b0;
         end else begin
            case (r_mode)
               MODE_OFF: begin
                  r_duty <= '0;
               end
               MODE_STATIC: begin
                  r_duty <= r_target;
               end
               MODE_BREATHE: begin
                  if (w_update_tick) begin
                     if (r_target == '0) begin
                        r_duty <= '0;
                     end else if (!r_dir_down) begin
                        if (w_sum >= {1'b0, r_target}) begin
                           r_duty     <= r_target;
                           r_dir_down <= 1'b1;
                        end else begin
                           r_duty <= w_sum[DW-1:0];
                        end
                     end else begin
                        if ({1'b0, r_duty} <= L_STEP_X) begin
                           r_duty     <= '0;
                           r_dir_down <= 1'b0;
                        end else begin
                           r_duty <= r_duty - L_STEP;
                        end
                     end
                  end
               end
               default: begin
                  // BLINK: alternate between dark and target
                  if (w_update_tick) begin
                     r_duty <= (r_duty == '0) ? r_target : '0;
                  end
               end
            endcase
         end
      end

      // Applied duty only changes at period boundaries, never mid-period
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_applied <= '0;
         end else if (w_period_tick) begin
            r_applied <= r_duty;
         end
      end

      // Registered PWM compare with polarity applied
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_pwm <= L_IDLE;
         end else begin
            r_pwm <= (r_pwm_cnt < r_applied) ^ L_IDLE;
         end
      end

      assign pwm_out[gi] = r_pwm;
   end

endmodule

// File: tb/tb_led_fade_array.sv
// tb_led_fade_array: directed stimulus with a period-indexed scoreboard.
// The stimulus pushes the expected active-clock count of every channel for
// each PWM period; the monitor counts active samples per period and compares.
module tb_led_fade_array;

   localparam int N_CH           = 3;
   localparam int PWM_INTERVAL   = 10;
   localparam int UPDATE_PERIODS = 2;
   localparam int STEP           = 2;
   localparam int ACTIVE_LOW     = 1;
   localparam int DW             = 4;
   localparam int CHW            = 2;
   localparam int NPER           = 32;
   localparam int NWR            = 7;

   logic            clk      = 1'b0;
   logic            rst_n    = 1'b0;
   logic            wr_en    = 1'b0;
   logic [CHW-1:0]  wr_ch    = '0;
   logic [1:0]      wr_mode  = '0;
   logic [DW-1:0]   wr_level = '0;
   logic [N_CH-1:0] pwm_out;
   logic            period_tick;
   logic            update_tick;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int per;
      int c0;
      int c1;
      int c2;
      int upd;
   } row_t;

   row_t sb_q[$];

   // Write schedule: issued at the period_tick that ends period wr_at
   int wr_at  [NWR] = '{1, 3, 5, 6, 8, 20, 25};
   int wr_chn [NWR] = '{0, 1, 1, 3, 2, 1, 1};
   int wr_md  [NWR] = '{1, 1, 1, 1, 2, 3, 3};
   int wr_lv  [NWR] = '{3, 15, 0, 7, 4, 10, 6};

   // Hand-computed active clocks per period (period index 0..31)
   int exp_c0 [NPER] = '{0, 0, 0, 3, 3, 3, 3, 3, 3, 3,
                         3, 3, 3, 3, 3, 3, 3, 3, 3, 3,
                         3, 3, 3, 3, 3, 3, 3, 3, 3, 3,
                         3, 3};
   int exp_c1 [NPER] = '{0, 0, 0, 0, 0, 10, 10, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 10, 10, 0, 0, 0, 0, 6,
                         6, 0};
   int exp_c2 [NPER] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         0, 2, 2, 4, 4, 2, 2, 0, 0, 2,
                         2, 4, 4, 2, 2, 0, 0, 2, 2, 4,
                         4, 2};

   led_fade_array #(
      .N_CH           (N_CH),
      .PWM_INTERVAL   (PWM_INTERVAL),
      .UPDATE_PERIODS (UPDATE_PERIODS),
      .STEP           (STEP),
      .ACTIVE_LOW     (ACTIVE_LOW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_mode     (wr_mode),
      .wr_level    (wr_level),
      .pwm_out     (pwm_out),
      .period_tick (period_tick),
      .update_tick (update_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic push_row(input int p, input int c0, input int c1, input int c2);
      row_t r;
      r.per = p;
      r.c0  = c0;
      r.c1  = c1;
      r.c2  = c2;
      r.upd = ((p % UPDATE_PERIODS) == (UPDATE_PERIODS - 1)) ? 1 : 0;
      sb_q.push_back(r);
   endtask

   task automatic next_tick(output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!period_tick && waited < 3 * PWM_INTERVAL);
      if (!period_tick) begin
         n_chk++;
         n_fail++;
         $display("FAIL period_tick timeout: none in %0d clocks, required within %0d",
                  waited, PWM_INTERVAL);
      end
   endtask

   task automatic do_write(input int ch, input int mode, input int lvl);
      wr_en    = 1'b1;
      wr_ch    = CHW'(ch);
      wr_mode  = 2'(mode);
      wr_level = DW'(lvl);
      $display("write ch=%0d mode=%0d level=%0d", ch, mode, lvl);
      @(negedge clk);
      wr_en    = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " pwm_out idle"}, int'(pwm_out), 7);
      check({tag, " period_tick low"}, int'(period_tick), 0);
      check({tag, " update_tick low"}, int'(update_tick), 0);
   endtask

   // Monitor: accumulate active samples per PWM period and score each period
   initial begin : monitor
      int   acc [N_CH];
      int   tick_prev;
      int   upd_seen;
      int   per;
      row_t r;
      tick_prev = 0;
      upd_seen  = 0;
      per       = 0;
      for (int c = 0; c < N_CH; c++) acc[c] = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) acc[c] = 0;
            tick_prev = 0;
            upd_seen  = 0;
            per       = 0;
         end else begin
            for (int c = 0; c < N_CH; c++) begin
               if (pwm_out[c] == 1'b0) acc[c]++;
            end
            if (update_tick) upd_seen = 1;
            if (tick_prev != 0) begin
               // Output lags the counter by one clock, so the window closes here
               while (sb_q.size() > 0 && sb_q[0].per < per) begin
                  r = sb_q.pop_front();
                  check("scoreboard row period", per, r.per);
               end
               if (sb_q.size() > 0 && sb_q[0].per == per) begin
                  r = sb_q.pop_front();
                  check($sformatf("p%0d ch0 active clocks", per), acc[0], r.c0);
                  check($sformatf("p%0d ch1 active clocks", per), acc[1], r.c1);
                  check($sformatf("p%0d ch2 active clocks", per), acc[2], r.c2);
                  check($sformatf("p%0d update_tick", per), upd_seen, r.upd);
               end
               for (int c = 0; c < N_CH; c++) acc[c] = 0;
               upd_seen = 0;
               per++;
            end
            tick_prev = period_tick ? 1 : 0;
         end
      end
   end

   // Stimulus
   initial begin : stim
      int w;
      repeat (3) @(negedge clk);
      check_reset("power-on reset");
      #1 rst_n = 1'b1;

      for (int p = 0; p < NPER; p++) begin
         push_row(p, exp_c0[p], exp_c1[p], exp_c2[p]);
         next_tick(w);
         if (p == 0) check("clocks to first period_tick", w, PWM_INTERVAL - 1);
         for (int k = 0; k < NWR; k++) begin
            if (wr_at[k] == p) do_write(wr_chn[k], wr_md[k], wr_lv[k]);
         end
      end

      // Mid-period reset while ch2 breathes: sample at pwm_cnt 0 of period 32
      @(negedge clk);
      @(negedge clk);
      check("pwm_out before mid-period reset", int'(pwm_out), 2);
      #2 rst_n = 1'b0;
      #1 check_reset("mid-period reset");
      repeat (2) @(negedge clk);
      check_reset("held reset");
      #1 rst_n = 1'b1;

      // After reset every channel must be OFF
      for (int p = 0; p < 3; p++) push_row(p, 0, 0, 0);
      for (int p = 0; p < 3; p++) begin
         next_tick(w);
         if (p == 0) check("clocks to first period_tick after reset", w, PWM_INTERVAL - 1);
      end
      @(negedge clk);
      @(negedge clk);
      check("scoreboard leftover rows", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global time bound
   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
      $fatal(1, "watchdog");
   end

endmodule
